// File: rtl/w5300_bus_if_if.sv
// Bundle of requester-side and W5300-side signals for the direct-address bus engine.
// The slave modport is the engine's view; the master modport is the requester plus the chip.
interface w5300_bus_if_if;
    logic        en;
    logic [10:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        op_state;
    logic [9:0]  w5300_addr;
    logic [15:0] w5300_data_o;
    logic        w5300_data_oe;
    logic [15:0] w5300_data_i;
    logic        w5300_cs_n;
    logic        w5300_rd_n;
    logic        w5300_wr_n;

    modport slave (
        input  en, addr, wr_data, w5300_data_i,
        output rd_data, op_state, w5300_addr, w5300_data_o, w5300_data_oe,
               w5300_cs_n, w5300_rd_n, w5300_wr_n
    );

    modport master (
        output en, addr, wr_data, w5300_data_i,
        input  rd_data, op_state, w5300_addr, w5300_data_o, w5300_data_oe,
               w5300_cs_n, w5300_rd_n, w5300_wr_n
    );
endinterface

// File: rtl/w5300_bus_if.sv
// W5300 direct-address bus engine: one timed CS/RD/WR cycle per request, all outputs registered.
// A single down-counter times every phase and is reloaded on phase entry.
module w5300_bus_if #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned STROBE_CYCLES  = 7,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    w5300_bus_if_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;
    logic             cs_n_q;
    logic             rd_n_q;
    logic             wr_n_q;
    logic             oe_q;
    logic             op_q;
    logic [9:0]       addr_q;
    logic [15:0]      data_o_q;
    logic [15:0]      rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            op_q      <= 1'b0;
            addr_q    <= '0;
            data_o_q  <= '0;
            rd_data_q <= '0;
        end else begin
            op_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        // The bus registers double as the latched copy of the request.
                        wr_q   <= bus.addr[10];
                        addr_q <= bus.addr[9:0];
                        if (bus.addr[10]) begin
                            data_o_q <= bus.wr_data;
                            oe_q     <= 1'b1;
                        end
                        cs_n_q  <= 1'b0;
                        cnt_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        if (wr_q) wr_n_q <= 1'b0;
                        else      rd_n_q <= 1'b0;
                        cnt_q   <= STROBE_LD;
                        state_q <= STROBE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        // Capture on the edge that ends the strobe, while RD_n is still low.
                        if (!wr_q) rd_data_q <= bus.w5300_data_i;
                        rd_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        cnt_q   <= HOLD_LD;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cs_n_q  <= 1'b1;
                        oe_q    <= 1'b0;
                        op_q    <= 1'b1;
                        cnt_q   <= RECOVER_LD;
                        state_q <= RECOVER;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.op_state      = op_q;
    assign bus.w5300_addr    = addr_q;
    assign bus.w5300_data_o  = data_o_q;
    assign bus.w5300_data_oe = oe_q;
    assign bus.w5300_cs_n    = cs_n_q;
    assign bus.w5300_rd_n    = rd_n_q;
    assign bus.w5300_wr_n    = wr_n_q;
endmodule

// File: tb/tb_w5300_bus_if.sv
// Directed bench for w5300_bus_if: vector table of single accesses plus multi-cycle sequences
// for back-to-back operation, non-default timing, en drop and reset mid-access.
module tb_w5300_bus_if;
    logic clk = 1'b0;
    logic rst;
    logic [15:0] chip_val;

    always #5 clk = ~clk;

    w5300_bus_if_if bus_a ();
    w5300_bus_if_if bus_b ();

    // Chip model: drives data only while RD_n is low, otherwise an obviously wrong pattern.
    assign bus_a.w5300_data_i = bus_a.w5300_rd_n ? 16'hDEAD : chip_val;
    assign bus_b.w5300_data_i = 16'h0000;

    w5300_bus_if dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    w5300_bus_if #(
        .SETUP_CYCLES   (2),
        .STROBE_CYCLES  (3),
        .HOLD_CYCLES    (2),
        .RECOVER_CYCLES (1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic        wr;
        logic [9:0]  a;
        logic [15:0] wd;
        logic [15:0] chip;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [4];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One isolated access on dut_a; request inputs are scrambled after the latch.
    task automatic do_access(input vec_t v, input string nm);
        int cs_low = 0, rd_low = 0, wr_low = 0, oe_hi = 0, lat = -1, pulses = 0, bad = 0;
        @(negedge clk);
        chip_val      = v.chip;
        bus_a.addr    = {v.wr, v.a};
        bus_a.wr_data = v.wd;
        bus_a.en      = 1'b1;
        @(posedge clk);
        #1;
        bus_a.en      = 1'b0;
        bus_a.addr    = ~bus_a.addr;
        bus_a.wr_data = ~bus_a.wr_data;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (!bus_a.w5300_cs_n) begin
                cs_low++;
                if (bus_a.w5300_addr !== v.a) bad++;
            end
            if (!bus_a.w5300_rd_n) rd_low++;
            if (!bus_a.w5300_wr_n) begin
                wr_low++;
                if (bus_a.w5300_data_o !== v.wd || !bus_a.w5300_data_oe) bad++;
            end
            if (!bus_a.w5300_rd_n && !bus_a.w5300_wr_n) bad++;
            if (bus_a.w5300_data_oe) oe_hi++;
            if (bus_a.op_state) begin
                pulses++;
                if (lat < 0) lat = c;
            end
        end
        check({nm, " cs_low"}, cs_low, 9);
        check({nm, " rd_low"}, rd_low, v.wr ? 0 : 7);
        check({nm, " wr_low"}, wr_low, v.wr ? 7 : 0);
        check({nm, " oe_cycles"}, oe_hi, v.wr ? 9 : 0);
        check({nm, " op_latency"}, lat, 10);
        check({nm, " op_pulses"}, pulses, 1);
        check({nm, " bus_errors"}, bad, 0);
        check({nm, " rd_data"}, bus_a.rd_data, v.exp_rd);
    endtask

    initial begin
        logic [9:0] seq_a [3];
        logic [9:0] seen  [3];
        int         op_t  [3];
        logic       cs_t  [24];
        logic       wr_t  [24];
        logic       op_tb [24];
        logic [15:0] dat_t [24];
        int ops, nstart, gap, min_gap, pulses, cs_low, rdcnt;
        int s0, w0, w1, c1, c2, o1, o2;
        logic prev_cs, change_next;

        vecs[0] = '{wr: 1'b0, a: 10'h3FE, wd: 16'h0000, chip: 16'h5300, exp_rd: 16'h5300};
        vecs[1] = '{wr: 1'b1, a: 10'h200, wd: 16'h0040, chip: 16'h1111, exp_rd: 16'h5300};
        vecs[2] = '{wr: 1'b0, a: 10'h001, wd: 16'hFFFF, chip: 16'hA5A5, exp_rd: 16'hA5A5};
        vecs[3] = '{wr: 1'b1, a: 10'h3FF, wd: 16'hFFFF, chip: 16'h2222, exp_rd: 16'hA5A5};

        rst = 1'b1;
        chip_val = 16'h0000;
        bus_a.en = 1'b0; bus_a.addr = '0; bus_a.wr_data = '0;
        bus_b.en = 1'b0; bus_b.addr = '0; bus_b.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset cs_n", bus_a.w5300_cs_n, 1);
        check("reset rd_n", bus_a.w5300_rd_n, 1);
        check("reset wr_n", bus_a.w5300_wr_n, 1);
        check("reset oe", bus_a.w5300_data_oe, 0);
        check("reset addr", bus_a.w5300_addr, 0);
        check("reset data_o", bus_a.w5300_data_o, 0);
        check("reset rd_data", bus_a.rd_data, 0);
        check("reset op_state", bus_a.op_state, 0);

        for (int i = 0; i < 4; i++) do_access(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back reads; requester switches address on the cycle after op_state.
        seq_a[0] = 10'h011; seq_a[1] = 10'h022; seq_a[2] = 10'h033;
        seen[0] = '0; seen[1] = '0; seen[2] = '0;
        op_t[0] = 0; op_t[1] = 0; op_t[2] = 0;
        ops = 0; nstart = 0; gap = 0; min_gap = 99; prev_cs = 1'b1; change_next = 1'b0;
        @(negedge clk);
        chip_val = 16'h0101;
        bus_a.addr = {1'b0, seq_a[0]};
        bus_a.en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!bus_a.w5300_cs_n && prev_cs) begin
                if (nstart < 3) seen[nstart] = bus_a.w5300_addr;
                nstart++;
                if (nstart > 1 && gap < min_gap) min_gap = gap;
            end
            if (bus_a.w5300_cs_n) gap++;
            else gap = 0;
            prev_cs = bus_a.w5300_cs_n;
            if (change_next) begin
                change_next = 1'b0;
                if (ops < 3) bus_a.addr = {1'b0, seq_a[ops]};
                else bus_a.en = 1'b0;
            end
            if (bus_a.op_state) begin
                if (ops < 3) op_t[ops] = c;
                ops++;
                change_next = 1'b1;
            end
        end
        check("b2b op_count", ops, 3);
        check("b2b accesses", nstart, 3);
        check("b2b period1", op_t[1] - op_t[0], 12);
        check("b2b period2", op_t[2] - op_t[1], 12);
        check("b2b addr0", seen[0], seq_a[0]);
        check("b2b addr1", seen[1], seq_a[1]);
        check("b2b addr2", seen[2], seq_a[2]);
        check("b2b cs_gap_ge2", min_gap >= 2, 1);
        check("b2b rd_data", bus_a.rd_data, 16'h0101);

        // Non-default timing on dut_b: two back-to-back writes.
        @(negedge clk);
        bus_b.addr = {1'b1, 10'h123};
        bus_b.wr_data = 16'h5A5A;
        bus_b.en = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            cs_t[c] = bus_b.w5300_cs_n;
            wr_t[c] = bus_b.w5300_wr_n;
            op_tb[c] = bus_b.op_state;
            dat_t[c] = bus_b.w5300_data_o;
            if (c == 12) bus_b.en = 1'b0;
        end
        s0 = -1; w0 = -1; w1 = -1; c1 = -1; c2 = -1; o1 = -1; o2 = -1;
        for (int c = 1; c <= 23; c++) begin
            if (s0 < 0 && !cs_t[c]) s0 = c;
            if (w0 < 0 && !wr_t[c]) w0 = c;
            if (w0 > 0 && w1 < 0 && c > w0 && wr_t[c]) w1 = c;
            if (w1 > 0 && c1 < 0 && c > w1 && cs_t[c]) c1 = c;
            if (c1 > 0 && c2 < 0 && c > c1 && !cs_t[c]) c2 = c;
            if (op_tb[c]) begin
                if (o1 < 0) o1 = c;
                else if (o2 < 0) o2 = c;
            end
        end
        check("t4 setup_start", s0, 1);
        check("t4 setup_width", w0 - s0, 2);
        check("t4 strobe_width", w1 - w0, 3);
        check("t4 hold_width", c1 - w1, 2);
        check("t4 recover_width", c2 - c1 - 1, 1);
        check("t4 op_in_recover", o1, c1);
        check("t4 op_period", o2 - o1, 9);
        check("t4 data_o", (w0 > 0) ? dat_t[w0] : 16'h0, 16'h5A5A);

        // en dropped while the strobe is active.
        pulses = 0; cs_low = 0; rdcnt = 0;
        @(negedge clk);
        chip_val = 16'hBEEF;
        bus_a.addr = {1'b0, 10'h0AA};
        bus_a.en = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (!bus_a.w5300_rd_n) begin
                rdcnt++;
                if (rdcnt == 3) bus_a.en = 1'b0;
            end
            if (!bus_a.w5300_cs_n) cs_low++;
            if (bus_a.op_state) pulses++;
        end
        check("endrop reached_strobe", rdcnt, 7);
        check("endrop op_pulses", pulses, 1);
        check("endrop cs_low", cs_low, 9);
        check("endrop rd_data", bus_a.rd_data, 16'hBEEF);

        // Reset during the strobe of a write.
        @(negedge clk);
        bus_a.addr = {1'b1, 10'h155};
        bus_a.wr_data = 16'h7777;
        bus_a.en = 1'b1;
        @(posedge clk);
        #1;
        bus_a.en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst pre wr_n", bus_a.w5300_wr_n, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst cs_n", bus_a.w5300_cs_n, 1);
        check("rst rd_n", bus_a.w5300_rd_n, 1);
        check("rst wr_n", bus_a.w5300_wr_n, 1);
        check("rst oe", bus_a.w5300_data_oe, 0);
        check("rst op_state", bus_a.op_state, 0);
        check("rst rd_data", bus_a.rd_data, 0);
        rst = 1'b0;
        pulses = 0; cs_low = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (bus_a.op_state) pulses++;
            if (!bus_a.w5300_cs_n) cs_low++;
        end
        check("rst no_op", pulses, 0);
        check("rst stays_idle", cs_low, 0);
        do_access('{wr: 1'b0, a: 10'h155, wd: 16'h0000, chip: 16'h1234, exp_rd: 16'h1234}, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
